// File: rtl/ddr3_wb_bridge.sv
// Wishbone classic slave that streams word beats into a DDR3 controller's
// ping-pong write FIFO and out of its read FIFO, aborting on a stalled FIFO.
module ddr3_wb_bridge #(
    parameter logic [23:0] TIMEOUT = 24'd1000000
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_wbs_cyc,
    input  logic        i_wbs_stb,
    input  logic        i_wbs_we,
    input  logic [31:0] i_wbs_adr,
    input  logic [31:0] i_wbs_dat,
    output logic [31:0] o_wbs_dat,
    output logic        o_wbs_ack,

    output logic [27:0] o_address,
    output logic        o_write_en,
    output logic        o_read_en,

    input  logic [1:0]  i_if_write_ready,
    output logic [1:0]  o_if_write_activate,
    input  logic [23:0] i_if_write_fifo_size,
    output logic        o_if_write_strobe,
    output logic [31:0] o_if_write_data,

    input  logic        i_of_read_ready,
    output logic        o_of_read_activate,
    input  logic [23:0] i_of_read_size,
    output logic        o_of_read_strobe,
    input  logic [31:0] i_of_read_data,

    output logic        o_busy,
    output logic        o_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_WAIT,
        S_WR_DATA,
        S_WR_FLUSH,
        S_RD_WAIT,
        S_RD_DATA,
        S_RD_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [27:0] r_address;
    logic        r_write_en;
    logic        r_read_en;
    logic [1:0]  r_wr_act;
    logic        r_wr_stb;
    logic [31:0] r_wr_dat;
    logic        r_rd_act;
    logic        r_rd_stb;
    logic [31:0] r_rd_dat;
    logic        r_ack;
    logic        r_timeout;
    logic [23:0] r_count;
    logic [23:0] r_wait;

    logic        w_req;
    logic        w_in_wait;
    logic        w_wait_hit;
    logic        w_wr_beat;
    logic        w_rd_beat;
    logic        w_abort;
    logic        w_unused;

    assign w_req      = i_wbs_cyc & i_wbs_stb;
    assign w_in_wait  = (r_state == S_WR_WAIT) || (r_state == S_RD_WAIT);
    assign w_wait_hit = w_in_wait && ((r_wait + 24'd1) >= TIMEOUT);
    assign w_unused   = &{1'b0, i_wbs_adr[31:28]};

    // Next-state and beat qualification; cyc loss always wins so the bus can escape.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_beat   = 1'b0;
        w_rd_beat   = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt = i_wbs_we ? S_WR_WAIT : S_RD_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (!i_wbs_cyc) begin
                    w_state_nxt = S_WR_FLUSH;
                end else if ((i_if_write_ready != 2'b00) && (r_wr_act == 2'b00)) begin
                    w_state_nxt = S_WR_DATA;
                end else if (w_wait_hit) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end
            end
            S_WR_DATA: begin
                if (!i_wbs_cyc) begin
                    w_state_nxt = S_WR_FLUSH;
                end else if (r_count >= i_if_write_fifo_size) begin
                    w_state_nxt = S_WR_WAIT;
                end else if (i_wbs_stb && i_wbs_we && !r_ack) begin
                    w_wr_beat = 1'b1;
                end
            end
            S_WR_FLUSH: begin
                w_state_nxt = S_IDLE;
            end
            S_RD_WAIT: begin
                if (!i_wbs_cyc) begin
                    w_state_nxt = S_RD_DONE;
                end else if (i_of_read_ready && !r_rd_act) begin
                    w_state_nxt = S_RD_DATA;
                end else if (w_wait_hit) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end
            end
            S_RD_DATA: begin
                if (!i_wbs_cyc) begin
                    w_state_nxt = S_RD_DONE;
                end else if (r_count >= i_of_read_size) begin
                    w_state_nxt = S_RD_WAIT;
                end else if (i_wbs_stb && !i_wbs_we && !r_ack) begin
                    w_rd_beat = 1'b1;
                end
            end
            S_RD_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_address  <= '0;
            r_write_en <= 1'b0;
            r_read_en  <= 1'b0;
            r_wr_act   <= '0;
            r_wr_stb   <= 1'b0;
            r_wr_dat   <= '0;
            r_rd_act   <= 1'b0;
            r_rd_stb   <= 1'b0;
            r_rd_dat   <= '0;
            r_ack      <= 1'b0;
            r_timeout  <= 1'b0;
            r_count    <= '0;
            r_wait     <= '0;
        end else begin
            r_ack    <= w_wr_beat | w_rd_beat;
            r_wr_stb <= w_wr_beat;
            r_rd_stb <= w_rd_beat;
            if (w_wr_beat) begin
                r_wr_dat <= i_wbs_dat;
            end
            if (w_rd_beat) begin
                r_rd_dat <= i_of_read_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_address  <= i_wbs_adr[27:0];
                        r_write_en <= i_wbs_we;
                        r_read_en  <= !i_wbs_we;
                        r_timeout  <= 1'b0;
                    end
                end
                S_WR_WAIT: begin
                    if (w_state_nxt == S_WR_DATA) begin
                        r_wr_act <= i_if_write_ready[0] ? 2'b01 : 2'b10;
                        r_count  <= '0;
                    end
                end
                S_WR_DATA: begin
                    if (w_state_nxt != S_WR_DATA) begin
                        r_wr_act <= '0;
                    end else if (w_wr_beat) begin
                        r_count <= r_count + 24'd1;
                    end
                end
                S_WR_FLUSH: begin
                    r_write_en <= 1'b0;
                end
                S_RD_WAIT: begin
                    if (w_state_nxt == S_RD_DATA) begin
                        r_rd_act <= 1'b1;
                        r_count  <= '0;
                    end else if (w_state_nxt == S_RD_DONE) begin
                        r_read_en <= 1'b0;
                    end
                end
                S_RD_DATA: begin
                    if (w_state_nxt != S_RD_DATA) begin
                        r_rd_act <= 1'b0;
                        if (w_state_nxt == S_RD_DONE) begin
                            r_read_en <= 1'b0;
                        end
                    end else if (w_rd_beat) begin
                        r_count <= r_count + 24'd1;
                    end
                end
                default: begin
                end
            endcase

            if (w_abort) begin
                r_timeout  <= 1'b1;
                r_write_en <= 1'b0;
                r_read_en  <= 1'b0;
                r_wr_act   <= '0;
                r_rd_act   <= 1'b0;
            end

            // Stall timer only advances while parked waiting on a FIFO.
            if ((w_state_nxt != r_state) || w_wr_beat || w_rd_beat) begin
                r_wait <= '0;
            end else if (w_in_wait) begin
                r_wait <= r_wait + 24'd1;
            end
        end
    end

    assign o_address           = r_address;
    assign o_write_en          = r_write_en;
    assign o_read_en           = r_read_en;
    assign o_if_write_activate = r_wr_act;
    assign o_if_write_strobe   = r_wr_stb;
    assign o_if_write_data     = r_wr_dat;
    assign o_of_read_activate  = r_rd_act;
    assign o_of_read_strobe    = r_rd_stb;
    assign o_wbs_dat           = r_rd_dat;
    assign o_wbs_ack           = r_ack;
    assign o_timeout           = r_timeout;
    assign o_busy              = (r_state != S_IDLE);

endmodule

// File: tb/tb_ddr3_wb_bridge.sv
// Scoreboard bench for ddr3_wb_bridge: directed Wishbone bursts against simple
// FIFO stand-ins, with expected beats queued at issue and checked by a monitor.
module tb_ddr3_wb_bridge;

    logic        clk;
    logic        rst_n;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [1:0]  wr_ready_cfg;
    logic [1:0]  wr_used;
    logic [23:0] wr_size;
    logic        rd_ready_cfg;
    logic [23:0] rd_size;
    logic [31:0] rd_idx;

    logic [31:0] o_wbs_dat;
    logic        o_wbs_ack;
    logic [27:0] o_address;
    logic        o_write_en;
    logic        o_read_en;
    logic [1:0]  i_if_write_ready;
    logic [1:0]  o_if_write_activate;
    logic        o_if_write_strobe;
    logic [31:0] o_if_write_data;
    logic        o_of_read_activate;
    logic        o_of_read_strobe;
    logic [31:0] i_of_read_data;
    logic        o_busy;
    logic        o_timeout;

    int n_checks;
    int n_fail;
    logic prev_ack;
    logic [33:0] wr_q[$];
    logic [31:0] rd_q[$];

    assign i_if_write_ready = wr_ready_cfg & ~wr_used;
    assign i_of_read_data   = 32'h0000_00A0 + rd_idx;

    ddr3_wb_bridge #(.TIMEOUT(24'd16)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_wbs_cyc            (wb_cyc),
        .i_wbs_stb            (wb_stb),
        .i_wbs_we             (wb_we),
        .i_wbs_adr            (wb_adr),
        .i_wbs_dat            (wb_dat),
        .o_wbs_dat            (o_wbs_dat),
        .o_wbs_ack            (o_wbs_ack),
        .o_address            (o_address),
        .o_write_en           (o_write_en),
        .o_read_en            (o_read_en),
        .i_if_write_ready     (i_if_write_ready),
        .o_if_write_activate  (o_if_write_activate),
        .i_if_write_fifo_size (wr_size),
        .o_if_write_strobe    (o_if_write_strobe),
        .o_if_write_data      (o_if_write_data),
        .i_of_read_ready      (rd_ready_cfg),
        .o_of_read_activate   (o_of_read_activate),
        .i_of_read_size       (rd_size),
        .o_of_read_strobe     (o_of_read_strobe),
        .i_of_read_data       (i_of_read_data),
        .o_busy               (o_busy),
        .o_timeout            (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // FIFO stand-ins: a write FIFO once taken stays unready for the rest of the bus cycle.
    always @(negedge clk) begin
        if (!wb_cyc) begin
            wr_used = 2'b00;
            rd_idx  = 32'd0;
        end else begin
            wr_used = wr_used | o_if_write_activate;
            if (o_of_read_strobe) rd_idx = rd_idx + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_wbs_ack) chk("ack_not_back_to_back", 32'(prev_ack), 32'd0);
            if (o_if_write_strobe) begin
                chk("wr_beat_expected", 32'(wr_q.size() > 0), 32'd1);
                if (wr_q.size() > 0) begin
                    logic [33:0] e;
                    e = wr_q.pop_front();
                    chk("wr_data", o_if_write_data, e[31:0]);
                    chk("wr_fifo_sel", 32'(o_if_write_activate), 32'(e[33:32]));
                    chk("wr_ack_with_strobe", 32'(o_wbs_ack), 32'd1);
                end
            end
            if (o_of_read_strobe) begin
                chk("rd_beat_expected", 32'(rd_q.size() > 0), 32'd1);
                if (rd_q.size() > 0) begin
                    logic [31:0] e;
                    e = rd_q.pop_front();
                    chk("rd_data", o_wbs_dat, e);
                    chk("rd_ack_with_strobe", 32'(o_wbs_ack), 32'd1);
                end
            end
        end
        prev_ack = o_wbs_ack;
    end

    task automatic wb_write(input logic [31:0] adr, input int n, input int split, output int acks);
        int t;
        acks = 0;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = adr;
        for (int i = 0; i < n; i++) begin
            wb_dat = 32'hD000_0000 + 32'(i);
            wr_q.push_back({(i < split) ? 2'b01 : 2'b10, wb_dat});
            t = 0;
            do begin @(negedge clk); t++; end while (!o_wbs_ack && t < 100);
            chk("wr_ack_in_time", 32'(o_wbs_ack), 32'd1);
            if (!o_wbs_ack) break;
            acks++;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] adr, input int n, output int acks);
        int t;
        acks = 0;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = adr;
        for (int i = 0; i < n; i++) begin
            rd_q.push_back(32'h0000_00A0 + 32'(i));
            t = 0;
            do begin @(negedge clk); t++; end while (!o_wbs_ack && t < 100);
            chk("rd_ack_in_time", 32'(o_wbs_ack), 32'd1);
            if (!o_wbs_ack) break;
            acks++;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    initial begin
        int t;
        int n;
        int acks;
        n_checks = 0; n_fail = 0; prev_ack = 1'b0;
        rst_n = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0; wb_dat = '0;
        wr_ready_cfg = 2'b01; wr_used = 2'b00; wr_size = 24'd64;
        rd_ready_cfg = 1'b1; rd_size = 24'd64; rd_idx = '0;

        repeat (3) @(negedge clk);
        chk("rst_address", 32'(o_address), 32'd0);
        chk("rst_enables", 32'({o_write_en, o_read_en}), 32'd0);
        chk("rst_activates", 32'({o_if_write_activate, o_of_read_activate}), 32'd0);
        chk("rst_ack_strobes", 32'({o_wbs_ack, o_if_write_strobe, o_of_read_strobe}), 32'd0);
        chk("rst_busy_timeout", 32'({o_busy, o_timeout}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 4-beat write into FIFO 0
        wr_ready_cfg = 2'b01;
        wb_write(32'h0000_0100, 4, 1000, acks);
        chk("w4_acks", 32'(acks), 32'd4);
        chk("w4_address", 32'(o_address), 32'h100);
        @(negedge clk);
        chk("w4_activate_released", 32'(o_if_write_activate), 32'd0);
        chk("w4_write_en_still_high", 32'(o_write_en), 32'd1);
        @(negedge clk);
        chk("w4_write_en_dropped", 32'(o_write_en), 32'd0);
        chk("w4_idle", 32'(o_busy), 32'd0);

        // 70-beat write: FIFO 0 fills at 64, remainder to FIFO 1
        wr_ready_cfg = 2'b11;
        wb_write(32'h0000_2000, 70, 64, acks);
        chk("w70_acks", 32'(acks), 32'd70);
        repeat (3) @(negedge clk);
        chk("w70_idle", 32'(o_busy), 32'd0);
        chk("w70_queue_drained", 32'(wr_q.size()), 32'd0);

        // we flipped mid-cycle after one beat: no further acks
        wr_ready_cfg = 2'b01;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h300; wb_dat = 32'hBEEF_0001;
        wr_q.push_back({2'b01, wb_dat});
        t = 0;
        do begin @(negedge clk); t++; end while (!o_wbs_ack && t < 100);
        chk("weflip_first_ack", 32'(o_wbs_ack), 32'd1);
        wb_we = 1'b0;
        n = 0;
        repeat (8) begin @(negedge clk); n += int'(o_wbs_ack); end
        chk("weflip_no_ack", 32'(n), 32'd0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (3) @(negedge clk);
        chk("weflip_idle", 32'(o_busy), 32'd0);

        // write with no FIFO ready: abort after 1 + 16 cycles
        wr_ready_cfg = 2'b00;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h200;
        t = 0;
        do begin @(negedge clk); t++; end while (!o_timeout && t < 40);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        chk("timeout_cycles", 32'(t), 32'd17);
        chk("timeout_flag", 32'(o_timeout), 32'd1);
        chk("timeout_enables", 32'({o_write_en, o_read_en}), 32'd0);
        chk("timeout_activate", 32'(o_if_write_activate), 32'd0);
        chk("timeout_idle", 32'(o_busy), 32'd0);
        @(negedge clk);
        chk("timeout_sticky", 32'(o_timeout), 32'd1);

        // 3-beat read; also clears the sticky timeout
        wb_read(32'h0000_0400, 3, acks);
        chk("r3_acks", 32'(acks), 32'd3);
        chk("r3_timeout_cleared", 32'(o_timeout), 32'd0);
        chk("r3_address", 32'(o_address), 32'h400);
        @(negedge clk);
        chk("r3_read_en_dropped", 32'(o_read_en), 32'd0);
        chk("r3_activate_dropped", 32'(o_of_read_activate), 32'd0);
        chk("r3_rd_done_busy", 32'(o_busy), 32'd1);
        @(negedge clk);
        chk("r3_idle", 32'(o_busy), 32'd0);

        // read FIFO of size 0 gives no beats
        rd_size = 24'd0;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h480;
        n = 0;
        repeat (10) begin @(negedge clk); n += int'(o_wbs_ack) + int'(o_of_read_strobe); end
        chk("rsize0_no_beats", 32'(n), 32'd0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (3) @(negedge clk);
        chk("rsize0_idle", 32'(o_busy), 32'd0);
        rd_size = 24'd64;

        // asynchronous reset in the middle of a read burst
        @(negedge clk);
        rd_q.push_back(32'h0000_00A0);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h500;
        t = 0;
        do begin @(negedge clk); t++; end while (!o_of_read_strobe && t < 40);
        chk("rstmid_first_beat", 32'(o_of_read_strobe), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_enables", 32'({o_write_en, o_read_en}), 32'd0);
        chk("rstmid_activates", 32'({o_if_write_activate, o_of_read_activate}), 32'd0);
        chk("rstmid_ack_strobes", 32'({o_wbs_ack, o_if_write_strobe, o_of_read_strobe}), 32'd0);
        chk("rstmid_rdata", o_wbs_dat, 32'd0);
        chk("rstmid_busy", 32'(o_busy), 32'd0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wb_read(32'h0000_0600, 3, acks);
        chk("rpost_acks", 32'(acks), 32'd3);
        chk("rpost_address", 32'(o_address), 32'h600);
        repeat (3) @(negedge clk);
        chk("rpost_idle", 32'(o_busy), 32'd0);
        chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
